// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory server.
package imem_pkg;

    typedef enum logic [1:0] {LOAD, HOLD, RUN} imem_state_t;

    // sll $0,$0,0 -- returned for any fetch that is not backed by loaded storage
    localparam logic [31:0] NOP_INST = 32'h0;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x 32 instruction storage: one synchronous write port, one synchronous
// read port, no reset so it maps onto block RAM.
module imem_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data
);

    logic [31:0] mem [DEPTH];

    // Write-then-registered-read; the two ports never touch the same word in
    // a cycle that matters because fetch is only honoured outside LOAD.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/imem_server.sv
// Instruction server for the five-stage core: loads a program from a host
// stream while holding the core in reset, then answers fetches with one cycle
// of latency. A reload request discards the program and restarts loading.
module imem_server
    import imem_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int HOLD_CYC = 4,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load_valid,
    input  logic [31:0]     load_data,
    input  logic            load_last,
    output logic            load_ready,
    input  logic            reload,
    input  logic [31:0]     pc,
    output logic [31:0]     inst,
    output logic            cpu_reset,
    output logic [ADDR_W:0] word_count,
    output logic            fetch_err
);

    localparam int HC_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYC - 1);
    localparam logic [ADDR_W:0]  LAST_IDX  = (ADDR_W + 1)'(DEPTH - 1);

    imem_state_t     state, state_next;
    logic [HC_W-1:0] hold_cnt;
    logic            xfer;
    logic            wr_en;
    logic            in_run;
    logic            aligned;
    logic            in_range;
    logic            in_prog;
    logic            legal;
    logic            legal_q;
    logic [31:0]     rd_data;
    logic [ADDR_W-1:0] fetch_idx;

    assign load_ready = (state == LOAD);
    assign xfer       = load_valid && load_ready;
    // Keep the array untouched while reset is held, matching "no transfer".
    assign wr_en      = xfer && reset_n;

    assign in_run    = (state == RUN);
    assign fetch_idx = pc[ADDR_W+1:2];
    assign aligned   = (pc[1:0] == 2'b00);
    assign in_range  = (pc[31:ADDR_W+2] == '0);
    assign in_prog   = ({1'b0, fetch_idx} < word_count);
    assign legal     = in_run && aligned && in_range && in_prog;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= LOAD;
        else          state <= state_next;
    end

    // Next-state: load ends on last beat or when storage fills; hold flushes
    // the core for HOLD_CYC cycles; reload from HOLD or RUN restarts loading.
    always_comb begin
        state_next = state;
        unique case (state)
            LOAD: if (xfer && (load_last || word_count == LAST_IDX)) state_next = HOLD;
            HOLD: begin
                if (reload)                     state_next = LOAD;
                else if (hold_cnt == HOLD_LAST) state_next = RUN;
            end
            RUN:  if (reload) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    // Load word counter and hold timer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_count <= '0;
            hold_cnt   <= '0;
        end else begin
            if (xfer)                        word_count <= word_count + 1'b1;
            else if (reload && !load_ready)  word_count <= '0;
            if (state == HOLD && !reload && hold_cnt != HOLD_LAST)
                hold_cnt <= hold_cnt + 1'b1;
            else
                hold_cnt <= '0;
        end
    end

    // Fetch qualification, sticky error, and core reset (lags state by one).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            legal_q   <= 1'b0;
            fetch_err <= 1'b0;
            cpu_reset <= 1'b1;
        end else begin
            legal_q   <= legal;
            cpu_reset <= (state != RUN);
            if (reload && !load_ready)
                fetch_err <= 1'b0;
            else if (in_run && (!aligned || !in_range))
                fetch_err <= 1'b1;
        end
    end

    imem_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (word_count[ADDR_W-1:0]),
        .wr_data (load_data),
        .rd_addr (fetch_idx),
        .rd_data (rd_data)
    );

    // legal_q lines up with the registered RAM read, so stale or unwritten
    // words never reach the core.
    assign inst = legal_q ? rd_data : NOP_INST;

endmodule

// File: tb/tb_imem_server.sv
// Directed bench for imem_server: fetch vector tables plus hand sequences for
// hold timing, illegal fetches, reload and mid-load reset.
module tb_imem_server;

    localparam int DEPTH    = 256;
    localparam int HOLD_CYC = 4;
    localparam int ADDR_W   = $clog2(DEPTH);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } fvec_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            load_valid = 1'b0;
    logic [31:0]     load_data = '0;
    logic            load_last = 1'b0;
    logic            load_ready;
    logic            reload = 1'b0;
    logic [31:0]     pc = '0;
    logic [31:0]     inst;
    logic            cpu_reset;
    logic [ADDR_W:0] word_count;
    logic            fetch_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] prog [DEPTH];

    imem_server #(.DEPTH(DEPTH), .HOLD_CYC(HOLD_CYC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .reload     (reload),
        .pc         (pc),
        .inst       (inst),
        .cpu_reset  (cpu_reset),
        .word_count (word_count),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Streams prog[0..n-1]; load_last optionally flags the final beat.
    task automatic load_prog(input int n, input bit use_last);
        for (int i = 0; i < n; i++) begin
            chk("load_ready_beat", load_ready, 1);
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = use_last && (i == n - 1);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // Counts edges until cpu_reset drops, bounded.
    task automatic wait_run(input int exp_edges);
        int k;
        k = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (!cpu_reset) begin
                k = i;
                break;
            end
        end
        chk("cpu_reset_fall_edges", k, exp_edges);
    endtask

    task automatic fetch(input fvec_t v);
        pc = v.pc;
        tick();
        chk("fetch_inst", inst, v.inst);
        chk("fetch_err", fetch_err, v.err);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    initial begin
        fvec_t va [4];
        fvec_t vb [4];
        va[0] = '{32'h0000_0000, 32'h2001_0005, 1'b0};
        va[1] = '{32'h0000_0004, 32'h2002_0007, 1'b0};
        va[2] = '{32'h0000_0008, 32'h0022_1820, 1'b0};
        va[3] = '{32'h0000_000C, 32'h0000_0000, 1'b0};
        vb[0] = '{32'(4 * (DEPTH - 1)), 32'hC0DE_0000 | 32'(DEPTH - 1), 1'b0};
        vb[1] = '{32'h0000_0000, 32'hC0DE_0000, 1'b0};
        vb[2] = '{32'(4 * 100), 32'hC0DE_0064, 1'b0};
        vb[3] = '{32'(4 * DEPTH), 32'h0000_0000, 1'b1};

        // Reset state
        repeat (2) tick();
        chk("rst_word_count", word_count, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_inst", inst, 0);
        chk("rst_fetch_err", fetch_err, 0);
        reset_n = 1'b1;

        // Idle in LOAD
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_load_ready", load_ready, 1);
            chk("idle_word_count", word_count, 0);
            chk("idle_cpu_reset", cpu_reset, 1);
        end

        // Three-word program with load_last
        prog[0] = 32'h2001_0005;
        prog[1] = 32'h2002_0007;
        prog[2] = 32'h0022_1820;
        load_prog(3, 1'b1);
        chk("a_word_count", word_count, 3);
        chk("a_load_ready_off", load_ready, 0);
        wait_run(HOLD_CYC + 1);
        foreach (va[i]) fetch(va[i]);

        // Illegal fetches set a sticky error
        fetch('{32'h0000_0402, 32'h0, 1'b1});
        fetch('{32'(4 * DEPTH), 32'h0, 1'b1});
        fetch('{32'h0000_0004, 32'h2002_0007, 1'b1});

        // Reload with a single word
        pulse_reload();
        chk("rl_fetch_err_clr", fetch_err, 0);
        chk("rl_word_count_clr", word_count, 0);
        prog[0] = 32'h3C01_ABCD;
        load_prog(1, 1'b1);
        chk("rl_cpu_reset", cpu_reset, 1);
        chk("rl_word_count", word_count, 1);
        wait_run(HOLD_CYC + 1);
        fetch('{32'h0000_0004, 32'h0, 1'b0});
        fetch('{32'h0000_0000, 32'h3C01_ABCD, 1'b0});

        // Reset after 2 of 4 beats, then a full 4-word load
        pulse_reload();
        prog[0] = 32'h1111_1111;
        prog[1] = 32'h2222_2222;
        prog[2] = 32'h3333_3333;
        prog[3] = 32'h4444_4444;
        load_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            load_data = prog[i];
            tick();
        end
        reset_n = 1'b0;
        #1;
        chk("mid_rst_word_count", word_count, 0);
        chk("mid_rst_cpu_reset", cpu_reset, 1);
        chk("mid_rst_inst", inst, 0);
        load_valid = 1'b0;
        tick();
        tick();
        chk("mid_rst_hold_count", word_count, 0);
        reset_n = 1'b1;
        load_prog(4, 1'b1);
        chk("full4_word_count", word_count, 4);
        wait_run(HOLD_CYC + 1);
        fetch('{32'h0000_000C, 32'h4444_4444, 1'b0});
        fetch('{32'h0000_0000, 32'h1111_1111, 1'b0});

        // Fill storage without load_last: auto-terminates at DEPTH
        pulse_reload();
        for (int i = 0; i < DEPTH; i++) prog[i] = 32'hC0DE_0000 | 32'(i);
        load_prog(DEPTH, 1'b0);
        chk("fill_word_count", word_count, DEPTH);
        chk("fill_load_ready", load_ready, 0);
        load_valid = 1'b1;
        load_data  = 32'hDEAD_BEEF;
        tick();
        load_valid = 1'b0;
        chk("fill_no_extra", word_count, DEPTH);
        wait_run(HOLD_CYC);
        foreach (vb[i]) fetch(vb[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
